// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver with majority-vote sampling,
// false-start rejection, framing-error and break detection.
module uart_rx_os16 #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 19200,
  parameter int OS_RATE   = 16,
  parameter int TICK_DIV  = clk_freq / (baud_rate * OS_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       rx_busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    sub_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    smp;
  logic          tick;
  logic          maj;

  assign tick = (state != IDLE) &&
                (tick_cnt == TW'(TICK_DIV - 1));

  // third vote is the live sample taken on the sub_cnt 9 tick
  assign maj = (smp[0] & smp[1]) |
               (smp[0] & rx_s) |
               (smp[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_d        <= 1'b1;
      tick_cnt    <= '0;
      sub_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      smp         <= '0;
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (state != IDLE)
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        if (sub_cnt == 4'd7) smp[0] <= rx_s;
        if (sub_cnt == 4'd8) smp[1] <= rx_s;
      end

      unique case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            sub_cnt  <= '0;
            rx_busy  <= 1'b1;
          end
        end
        START: begin
          if (tick && sub_cnt == 4'd9 && maj) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (tick && sub_cnt == 4'd15) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (sub_cnt == 4'd9)
              shreg <= {maj, shreg[7:1]};
            if (sub_cnt == 4'd15) begin
              if (bit_cnt == 3'd7)
                state <= STOP;
              else
                bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick && sub_cnt == 4'd9) begin
            if (maj) begin
              rx_data_out <= shreg;
              rx_valid    <= 1'b1;
              state       <= IDLE;
              rx_busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              break_det <= ~rx_s;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) begin
            break_det <= 1'b0;
            state     <= IDLE;
            rx_busy   <= 1'b0;
          end else begin
            break_det <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: table of frames plus hand-written
// reset, back-to-back, glitch, break and abort sequences.
module tb_uart_rx_os16;

  localparam int BIT = 160;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       break_det;
  logic       rx_busy;

  uart_rx_os16 #(
    .clk_freq (1600000),
    .baud_rate(10000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data_out(rx_data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int vcnt = 0;
  int fcnt = 0;
  int overlap = 0;
  int unstable = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      got.push_back(rx_data_out);
    end
    if (frame_err) fcnt++;
    if (rx_valid && frame_err) overlap++;
    if (!rst && !rx_valid && rx_data_out != prev_data)
      unstable++;
    prev_data = rx_data_out;
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input int bclk);
    hold(1'b0, bclk);
    for (int i = 0; i < 8; i++) hold(d[i], bclk);
    hold(stop, bclk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, f0, b0, bad;
    logic [7:0] last_good;

    vecs[0] = '{8'hA5, 1'b1, 160, 1, 0, 8'hA5};
    vecs[1] = '{8'h81, 1'b1, 155, 1, 0, 8'h81};
    vecs[2] = '{8'h81, 1'b1, 165, 1, 0, 8'h81};
    vecs[3] = '{8'h0F, 1'b0, 160, 0, 1, 8'h81};
    vecs[4] = '{8'h5A, 1'b1, 160, 1, 0, 8'h5A};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) rx = ~rx;
      @(negedge clk);
      if (rx_valid || frame_err || break_det || rx_busy ||
          rx_data_out != 8'h00)
        bad++;
    end
    chk("reset_hold", bad, 0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_busy", int'(rx_busy), 0);
    chk("post_reset_data", int'(rx_data_out), 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) begin
      v0 = vcnt;
      f0 = fcnt;
      send(vecs[k].data, vecs[k].stop, vecs[k].bclk);
      hold(1'b1, 2 * BIT);
      chk($sformatf("vec%0d_valid", k), vcnt - v0,
          vecs[k].exp_valid);
      chk($sformatf("vec%0d_ferr", k), fcnt - f0,
          vecs[k].exp_ferr);
      chk($sformatf("vec%0d_data", k), int'(rx_data_out),
          int'(vecs[k].exp_data));
    end

    v0 = vcnt;
    b0 = got.size();
    send(8'h00, 1'b1, BIT);
    send(8'hFF, 1'b1, BIT);
    send(8'h3C, 1'b1, BIT);
    hold(1'b1, 2 * BIT);
    chk("b2b_count", vcnt - v0, 3);
    chk("b2b_0", got.size() > b0 ? int'(got[b0]) : -1, 'h00);
    chk("b2b_1", got.size() > b0 + 1 ? int'(got[b0+1]) : -1,
        'hFF);
    chk("b2b_2", got.size() > b0 + 2 ? int'(got[b0+2]) : -1,
        'h3C);
    last_good = 8'h3C;

    v0 = vcnt;
    f0 = fcnt;
    hold(1'b0, 50);
    hold(1'b1, 2 * BIT);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    chk("glitch_busy", int'(rx_busy), 0);

    v0 = vcnt;
    f0 = fcnt;
    send(8'h55, 1'b0, BIT);
    hold(1'b0, 3 * BIT);
    @(negedge clk);
    chk("brk_ferr", fcnt - f0, 1);
    chk("brk_valid", vcnt - v0, 0);
    chk("brk_det_high", int'(break_det), 1);
    chk("brk_data_held", int'(rx_data_out), int'(last_good));
    @(posedge clk);
    #1;
    hold(1'b1, 8);
    @(negedge clk);
    chk("brk_det_low", int'(break_det), 0);
    chk("brk_busy", int'(rx_busy), 0);
    @(posedge clk);
    #1;
    hold(1'b1, 2 * BIT);

    v0 = vcnt;
    f0 = fcnt;
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b1, BIT / 2);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 2 * BIT);
    chk("abort_valid", vcnt - v0, 0);
    chk("abort_ferr", fcnt - f0, 0);
    chk("abort_busy", int'(rx_busy), 0);
    chk("abort_data", int'(rx_data_out), 0);

    v0 = vcnt;
    send(8'h42, 1'b1, BIT);
    hold(1'b1, 2 * BIT);
    chk("after_abort_valid", vcnt - v0, 1);
    chk("after_abort_data", int'(rx_data_out), 'h42);

    chk("valid_ferr_overlap", overlap, 0);
    chk("data_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
